// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector and front-end stall controller for the 5-stage MIPS pipeline.
// Also arbitrates data-memory freezes and taken-branch flushes, and counts load-use bubbles.
module hazard_stall_ctrl #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idex_mem_read,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic              ifid_rs_used,
    input  logic              ifid_rt_used,
    input  logic              branch_taken,
    input  logic              mem_busy,
    input  logic              stat_clr,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              ctrl_bubble,
    output logic              ifid_flush,
    output logic              pipe_freeze,
    output logic [CNT_W-1:0]  stall_cycles
);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2
    } state_e;

    localparam logic [3:0]       CntInit    = 4'(LOAD_LAT - 1);
    localparam bit               MultiCycle = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0] StatOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] StatMax    = '1;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic rs_hit, rt_hit, hz;
    logic pc_hold_raw, ifid_hold_raw, bubble_raw, flush_raw, freeze_raw;
    logic count_bubble;

    // $zero is hard-wired, so a load targeting it can never create a real dependency.
    assign rs_hit = ifid_rs_used && (idex_rt == ifid_rs);
    assign rt_hit = ifid_rt_used && (idex_rt == ifid_rt);
    assign hz     = idex_mem_read && (idex_rt != '0) && (rs_hit || rt_hit);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_hold_raw   = 1'b0;
        ifid_hold_raw = 1'b0;
        bubble_raw    = 1'b0;
        flush_raw     = 1'b0;
        freeze_raw    = 1'b0;
        count_bubble  = 1'b0;

        if (mem_busy) begin
            pc_hold_raw   = 1'b1;
            ifid_hold_raw = 1'b1;
            freeze_raw    = 1'b1;
            if (state_q == StIdle) begin
                state_d = StMemWait;
            end
        end else if (branch_taken) begin
            flush_raw  = 1'b1;
            bubble_raw = 1'b1;
            state_d    = StIdle;
            cnt_d      = 4'd0;
        end else begin
            case (state_q)
                // MEM_WAIT drops back to IDLE and evaluates the hazard in the same cycle.
                StIdle, StMemWait: begin
                    state_d = StIdle;
                    if (hz) begin
                        pc_hold_raw   = 1'b1;
                        ifid_hold_raw = 1'b1;
                        bubble_raw    = 1'b1;
                        count_bubble  = 1'b1;
                        if (MultiCycle) begin
                            state_d = StLoadStall;
                            cnt_d   = CntInit;
                        end
                    end
                end
                StLoadStall: begin
                    pc_hold_raw   = 1'b1;
                    ifid_hold_raw = 1'b1;
                    bubble_raw    = 1'b1;
                    count_bubble  = 1'b1;
                    cnt_d         = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = StIdle;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (stat_clr) begin
            stall_d = '0;
        end else if (count_bubble && (stall_q != StatMax)) begin
            stall_d = stall_q + StatOne;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    // Control outputs are gated so they read 0 for the whole time reset is held.
    assign pc_hold      = rst_n & pc_hold_raw;
    assign ifid_hold    = rst_n & ifid_hold_raw;
    assign ctrl_bubble  = rst_n & bubble_raw;
    assign ifid_flush   = rst_n & flush_raw;
    assign pipe_freeze  = rst_n & freeze_raw;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: a LOAD_LAT=1/CNT_W=4 and a LOAD_LAT=3 instance share stimulus.
// Expectations are queued as each step is driven and popped when outputs are sampled.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic       idex_mem_read;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       ifid_rs_used, ifid_rt_used, branch_taken, mem_busy, stat_clr;

    logic       a_pc, a_ifid, a_bub, a_fl, a_fz;
    logic [3:0] a_cnt;
    logic       b_pc, b_ifid, b_bub, b_fl, b_fz;
    logic [15:0] b_cnt;

    int checks = 0;
    int failures = 0;

    // {pc_hold, ifid_hold, ctrl_bubble, ifid_flush, pipe_freeze}
    localparam logic [4:0] NONE   = 5'b00000;
    localparam logic [4:0] STALL  = 5'b11100;
    localparam logic [4:0] FLUSH  = 5'b00110;
    localparam logic [4:0] FREEZE = 5'b11001;

    typedef struct packed {
        logic        sel;
        logic [4:0]  out;
        logic [15:0] cnt;
    } exp_t;

    exp_t  sb[$];
    string tags[$];

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(4)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rs_used(ifid_rs_used),
        .ifid_rt_used(ifid_rt_used), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .stat_clr(stat_clr), .pc_hold(a_pc), .ifid_hold(a_ifid), .ctrl_bubble(a_bub),
        .ifid_flush(a_fl), .pipe_freeze(a_fz), .stall_cycles(a_cnt)
    );

    hazard_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_rs_used(ifid_rs_used),
        .ifid_rt_used(ifid_rt_used), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .stat_clr(stat_clr), .pc_hold(b_pc), .ifid_hold(b_ifid), .ctrl_bubble(b_bub),
        .ifid_flush(b_fl), .pipe_freeze(b_fz), .stall_cycles(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running req=finished");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic rsu, input logic rtu,
                         input logic br, input logic mb, input logic clr);
        idex_mem_read = mr;
        idex_rt       = xrt;
        ifid_rs       = rs;
        ifid_rt       = rt;
        ifid_rs_used  = rsu;
        ifid_rt_used  = rtu;
        branch_taken  = br;
        mem_busy      = mb;
        stat_clr      = clr;
    endtask

    task automatic expect_push(input logic sel, input logic [4:0] eo, input logic [15:0] ec,
                               input string tag);
        sb.push_back('{sel: sel, out: eo, cnt: ec});
        tags.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t        e;
        string       t;
        logic [4:0]  o;
        logic [15:0] c;
        e = sb.pop_front();
        t = tags.pop_front();
        o = e.sel ? {b_pc, b_ifid, b_bub, b_fl, b_fz} : {a_pc, a_ifid, a_bub, a_fl, a_fz};
        c = e.sel ? b_cnt : {12'd0, a_cnt};
        checks++;
        assert (o === e.out) else begin
            failures++;
            $error("FAIL %s outputs(pc,ifid,bub,flush,frz) obs=%b exp=%b", t, o, e.out);
        end
        checks++;
        assert (c === e.cnt) else begin
            failures++;
            $error("FAIL %s stall_cycles obs=%0d exp=%0d", t, c, e.cnt);
        end
    endtask

    task automatic step(input logic sel, input logic mr, input logic [4:0] xrt,
                        input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic br, input logic mb, input logic clr,
                        input logic [4:0] eo, input logic [15:0] ec, input string tag);
        @(posedge clk);
        #1;
        drive(mr, xrt, rs, rt, rsu, rtu, br, mb, clr);
        expect_push(sel, eo, ec, tag);
        @(negedge clk);
        check_pop();
    endtask

    // Load to r10 followed by a consumer reading r10 through rs.
    task automatic step_hz(input logic sel, input logic clr, input logic [4:0] eo,
                           input logic [15:0] ec, input string tag);
        step(sel, 1'b1, 5'd10, 5'd10, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, clr, eo, ec, tag);
    endtask

    task automatic step_idle(input logic sel, input logic br, input logic mb,
                             input logic [4:0] eo, input logic [15:0] ec, input string tag);
        step(sel, 1'b0, 5'd10, 5'd10, 5'd3, 1'b1, 1'b1, br, mb, 1'b0, eo, ec, tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b1, 5'd10, 5'd10, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        expect_push(1'b0, NONE, 16'd0, "reset_lat1");
        check_pop();
        expect_push(1'b1, NONE, 16'd0, "reset_lat3");
        check_pop();
        do_reset();

        // LOAD_LAT=1 basic detection
        step_hz(1'b0, 1'b0, STALL, 16'd0, "lat1_rs_hit");
        step_idle(1'b0, 1'b0, 1'b0, NONE, 16'd1, "lat1_after");
        step(1'b0, 1'b1, 5'd10, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 16'd1,
             "lat1_no_match");
        step(1'b0, 1'b1, 5'd10, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, STALL, 16'd1,
             "lat1_rt_hit");
        step_idle(1'b0, 1'b0, 1'b0, NONE, 16'd2, "lat1_after_rt");

        // $zero and unused-operand exemptions
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE, 16'd2, "zero_dst");
        step(1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, NONE, 16'd2,
             "rt_unused");
        step(1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NONE, 16'd2, "no_load");

        // LOAD_LAT=3 single hazard
        do_reset();
        step_hz(1'b1, 1'b0, STALL, 16'd0, "lat3_b1");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd1, "lat3_b2");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd2, "lat3_b3");
        step_idle(1'b1, 1'b0, 1'b0, NONE, 16'd3, "lat3_done");

        // LOAD_LAT=3 with a 2-cycle memory freeze mid-stall
        do_reset();
        step_hz(1'b1, 1'b0, STALL, 16'd0, "frz_b1");
        step_idle(1'b1, 1'b0, 1'b1, FREEZE, 16'd1, "frz_f1");
        step_idle(1'b1, 1'b0, 1'b1, FREEZE, 16'd1, "frz_f2");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd1, "frz_b2");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd2, "frz_b3");
        step_idle(1'b1, 1'b0, 1'b0, NONE, 16'd3, "frz_done");

        // LOAD_LAT=3 aborted by a taken branch, then MEM_WAIT exit into a fresh hazard
        do_reset();
        step_hz(1'b1, 1'b0, STALL, 16'd0, "br_b1");
        step_idle(1'b1, 1'b1, 1'b0, FLUSH, 16'd1, "br_flush");
        step_idle(1'b1, 1'b0, 1'b0, NONE, 16'd1, "br_idle1");
        step_idle(1'b1, 1'b0, 1'b0, NONE, 16'd1, "br_idle2");
        step_idle(1'b1, 1'b0, 1'b1, FREEZE, 16'd1, "mw_freeze");
        step_hz(1'b1, 1'b0, STALL, 16'd1, "mw_exit_hz");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd2, "mw_b2");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd3, "mw_b3");
        step_idle(1'b1, 1'b0, 1'b0, NONE, 16'd4, "mw_done");

        // CNT_W=4 saturation and clear
        do_reset();
        for (int k = 0; k < 17; k++) begin
            step_hz(1'b0, 1'b0, STALL, (k > 15) ? 16'd15 : 16'(k), "sat");
        end
        step_hz(1'b0, 1'b1, STALL, 16'd15, "clr_with_hz");
        step_idle(1'b0, 1'b0, 1'b0, NONE, 16'd0, "clr_result");

        // Asynchronous reset in the middle of a LOAD_STALL
        do_reset();
        step_hz(1'b1, 1'b0, STALL, 16'd0, "rst_b1");
        step_idle(1'b1, 1'b0, 1'b0, STALL, 16'd1, "rst_b2");
        drive(1'b1, 5'd10, 5'd10, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_push(1'b1, NONE, 16'd0, "rst_async");
        check_pop();
        #1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step_idle(1'b1, 1'b0, 1'b0, NONE, 16'd0, "rst_bubbles_lost");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised load-use hazard and stall controller for the 5-stage MIPS pipeline; sits between the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use hazards using per-operand "used" flags and exempts $zero.
- Holds the front end for a configurable number of load-latency cycles using an internal FSM.
- Also handles data-memory busy freezes and taken-branch IF/ID flushes with fixed priority, and keeps a saturating stall-cycle statistic.

Parameters:
REG_AW, 5, register-address width.
LOAD_LAT, 1, bubble cycles inserted per load-use hazard; legal range 1..15.
CNT_W, 16, width of the stall statistic counter.

Ports:
clk  input  1  pipeline clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
idex_mem_read  input  1  instruction in ID/EX is a load.
idex_rt  input  REG_AW  destination (rt) of the ID/EX load.
ifid_rs  input  REG_AW  rs field of the IF/ID instruction.
ifid_rt  input  REG_AW  rt field of the IF/ID instruction.
ifid_rs_used  input  1  IF/ID instruction reads rs.
ifid_rt_used  input  1  IF/ID instruction reads rt as a source (R-format, beq, sw data).
branch_taken  input  1  EX-stage branch resolved taken this cycle.
mem_busy  input  1  data memory not ready; whole pipeline must freeze.
stat_clr  input  1  synchronous clear of stall_cycles.
pc_hold  output  1  1 = PC does not update.
ifid_hold  output  1  1 = IF/ID register does not update.
ctrl_bubble  output  1  1 = zero control signals into ID/EX.
ifid_flush  output  1  1 = IF/ID loaded with NOP.
pipe_freeze  output  1  1 = ID/EX, EX/MEM and MEM/WB hold.
stall_cycles  output  CNT_W  count of load-use bubble cycles; saturating.

Behaviour:
- Hazard term:
  - hz = idex_mem_read && idex_rt != 0 && ((ifid_rs_used && idex_rt == ifid_rs) || (ifid_rt_used && idex_rt == ifid_rt)).
  - The $zero destination never stalls.
- FSM states and counter:
  - States: IDLE, LOAD_STALL, MEM_WAIT.
  - Internal down-counter cnt is 4 bits wide.
- Outputs are combinational from state and inputs. Priority, highest first:
  1. mem_busy = 1:
     - pc_hold = ifid_hold = pipe_freeze = 1; ctrl_bubble = ifid_flush = 0.
     - State and cnt are frozen (MEM_WAIT is entered from IDLE; LOAD_STALL stays in LOAD_STALL with cnt paused).
     - MEM_WAIT returns to IDLE on the first cycle mem_busy = 0, and hazard evaluation resumes that same cycle.
  2. branch_taken = 1:
     - ifid_flush = 1, ctrl_bubble = 1, pc_hold = ifid_hold = 0.
     - Any LOAD_STALL is aborted: next state IDLE, cnt = 0.
     - Not counted in stall_cycles.
  3. IDLE with hz = 1:
     - pc_hold = ifid_hold = ctrl_bubble = 1.
     - If LOAD_LAT > 1: next state LOAD_STALL, cnt = LOAD_LAT-1. Otherwise remain in IDLE.
  4. LOAD_STALL:
     - pc_hold = ifid_hold = ctrl_bubble = 1; cnt decrements each cycle.
     - Returns to IDLE when cnt == 1 and decrements.
     - hz is not re-evaluated while in LOAD_STALL.
  5. Otherwise all outputs are 0.
- Latency and counting:
  - Detection is same-cycle (zero latency).
  - Total bubbles per hazard = LOAD_LAT, excluding frozen cycles.
  - stall_cycles += 1 on each cycle in which ctrl_bubble = 1 due to priority 3 or 4.
  - stall_cycles saturates at 2^CNT_W-1.
  - stat_clr has priority over increment; next value = 0.
- Reset:
  - Asynchronous; state IDLE, cnt 0, stall_cycles 0.
  - All 1-bit outputs are forced to 0 while rst_n = 0.
  - Deassertion mid-stall leaves the FSM in IDLE; any pending bubbles are lost by design.
- Back-to-back loads:
  - A second hz detected in IDLE immediately after LOAD_STALL exits starts a fresh LOAD_LAT sequence.

Test Plan:
1. LOAD_LAT=1: idex_mem_read=1, idex_rt=10, ifid_rs=10, rs_used=1 -> pc_hold=ifid_hold=ctrl_bubble=1 for exactly 1 cycle; stall_cycles=1. Repeat with ifid_rs=9, rt_used=0 -> all outputs 0.
2. $zero exemption: idex_rt=0, ifid_rs=0, rs_used=1, idex_mem_read=1 -> no stall. Also rt match with rt_used=0 -> no stall.
3. LOAD_LAT=3: single hazard (ID/EX becomes bubble after the first cycle) -> ctrl_bubble high for exactly 3 consecutive cycles, then IDLE; stall_cycles=3.
4. LOAD_LAT=3, mem_busy=1 on the 2nd stall cycle for 2 cycles -> pipe_freeze=1 for 2 cycles, ctrl_bubble=0 during the freeze, then 2 more bubble cycles; stall_cycles=3.
5. LOAD_LAT=3, branch_taken=1 on the 2nd stall cycle -> ifid_flush=1 and pc_hold=0 that cycle; next cycle IDLE with all outputs 0; stall_cycles=1.
6. CNT_W=4: 17 single-cycle hazards -> stall_cycles saturates at 15. stat_clr coinciding with a hazard -> 0. Assert rst_n=0 mid-LOAD_STALL -> outputs 0 immediately, counter 0.
